// File: rtl/ball_motion_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ball_motion_ctrl
// Brief    : Fixed-point ball physics (gravity, walls, net, player hits) with a
//            serve/score FSM and per-side touch counting. Optional macro
//            BALL_TOUCH_LIMIT_EN enables the fourth-touch fault.
// Revision : 1.0 - initial release
// ============================================================================
module ball_motion_ctrl #(
  parameter int W         = 12,
  parameter int FRAC      = 4,
  parameter int TICK_DIV  = 1_000_000,
  parameter int SCR_W     = 800,
  parameter int GROUND_Y  = 560,
  parameter int BALL_R    = 20,
  parameter int GRAVITY   = 8,
  parameter int BOUNCE_VY = 160,
  parameter int VX_MAX    = 96,
  parameter int SERVE_X1  = 200,
  parameter int SERVE_X2  = 600,
  parameter int SERVE_Y   = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         serve,
  input  logic         serve_side,
  input  logic         pl1_col,
  input  logic         pl2_col,
  input  logic         net_col,
  input  logic [W-1:0] pl1_posx,
  input  logic [W-1:0] pl2_posx,
  output logic [W-1:0] ball_posx_out,
  output logic [W-1:0] ball_posy_out,
  output logic         gnd_col,
  output logic         ovr_touch,
  output logic         fault_side,
  output logic [1:0]   touch_cnt,
  output logic [1:0]   state_out
);
  localparam int PW = W + FRAC;
  localparam int VW = W + FRAC + 1;
  localparam int SW = W + FRAC + 2;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_FLIGHT = 2'd1;
  localparam logic [1:0] c_ST_SCORED = 2'd2;

  localparam logic signed [SW-1:0] c_X_MIN   = SW'(BALL_R << FRAC);
  localparam logic signed [SW-1:0] c_X_MAX   = SW'((SCR_W - BALL_R) << FRAC);
  localparam logic signed [SW-1:0] c_Y_GND   = SW'(GROUND_Y << FRAC);
  localparam logic signed [SW-1:0] c_HALF_FP = SW'((SCR_W / 2) << FRAC);
  localparam logic signed [VW-1:0] c_VX_MAX  = VW'(VX_MAX);
  localparam logic signed [VW-1:0] c_BOUNCE  = VW'(BOUNCE_VY);
  localparam logic signed [VW-1:0] c_GRAV    = VW'(GRAVITY);
  localparam logic [PW-1:0]        c_SX1     = PW'(SERVE_X1 << FRAC);
  localparam logic [PW-1:0]        c_SX2     = PW'(SERVE_X2 << FRAC);
  localparam logic [PW-1:0]        c_SY      = PW'(SERVE_Y << FRAC);
  localparam logic [PW-1:0]        c_Y_GND_P = PW'(GROUND_Y << FRAC);

  logic [1:0]           r_state, w_state_nxt;
  logic [TW-1:0]        r_tick_cnt;
  logic                 r_pl1_d, r_pl2_d, r_net_d;
  logic                 r_pl1_pend, r_pl2_pend, r_net_pend;
  logic [PW-1:0]        r_px, r_py;
  logic signed [VW-1:0] r_vx, r_vy;
  logic [1:0]           r_touch;
  logic                 r_last_side, r_gnd, r_ovr, r_fault;

  logic                 w_tick, w_flight_tick;
  logic                 w_hit1, w_hit2, w_hit, w_hit_side, w_over, w_ground, w_ground_side;
  logic [W-1:0]         w_pl_x;
  logic signed [W:0]    w_dx;
  logic signed [VW-1:0] w_vx_raw, w_vx_hit, w_vx1, w_vy1, w_vx2, w_vy2;
  logic signed [SW-1:0] w_x_sum, w_y_sum, w_x_wall, w_y_wall;
  logic [PW-1:0]        w_y_fin;
  logic [1:0]           w_touch_nxt;
  logic                 w_gnd_nxt, w_ovr_nxt, w_fault_nxt;

  assign w_tick        = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_flight_tick = w_tick && (r_state == c_ST_FLIGHT);

  // One physics step; only committed on a FLIGHT tick.
  always_comb begin
    w_hit1     = r_pl1_pend;
    w_hit2     = r_pl2_pend & ~r_pl1_pend;
    w_hit      = w_hit1 | w_hit2;
    w_hit_side = w_hit2;
    w_pl_x     = w_hit1 ? pl1_posx : pl2_posx;
    w_dx       = $signed({1'b0, r_px[PW-1:FRAC]}) - $signed({1'b0, w_pl_x});
    w_vx_raw   = $signed({{FRAC{w_dx[W]}}, w_dx}) <<< (FRAC - 1);
    if (w_vx_raw > c_VX_MAX)       w_vx_hit = c_VX_MAX;
    else if (w_vx_raw < -c_VX_MAX) w_vx_hit = -c_VX_MAX;
    else                           w_vx_hit = w_vx_raw;

    w_over      = 1'b0;
    w_touch_nxt = r_touch;
    if (w_hit) begin
      if (w_hit_side != r_last_side) begin
        w_touch_nxt = 2'd1;
      end else if (r_touch == 2'd3) begin
`ifdef BALL_TOUCH_LIMIT_EN
        w_over = 1'b1;
`endif
        w_touch_nxt = 2'd3;
      end else begin
        w_touch_nxt = r_touch + 2'd1;
      end
    end

    w_vx1 = w_hit ? w_vx_hit : r_vx;
    w_vy1 = w_hit ? -c_BOUNCE : (r_vy + c_GRAV);
    if (r_net_pend) w_vx1 = -w_vx1;

    w_x_sum  = $signed({2'b00, r_px}) + $signed({w_vx1[VW-1], w_vx1});
    w_y_sum  = $signed({2'b00, r_py}) + $signed({w_vy1[VW-1], w_vy1});
    w_x_wall = w_x_sum;
    w_y_wall = w_y_sum;
    w_vx2    = w_vx1;
    w_vy2    = w_vy1;
    if (w_x_sum < c_X_MIN) begin
      w_x_wall = c_X_MIN;
      w_vx2    = w_vx1[VW-1] ? -w_vx1 : w_vx1;
    end else if (w_x_sum > c_X_MAX) begin
      w_x_wall = c_X_MAX;
      w_vx2    = w_vx1[VW-1] ? w_vx1 : -w_vx1;
    end
    if (w_y_sum < c_X_MIN) begin
      w_y_wall = c_X_MIN;
      w_vy2    = w_vy1[VW-1] ? -w_vy1 : w_vy1;
    end
    w_ground      = (w_y_wall >= c_Y_GND);
    w_ground_side = (w_x_wall >= c_HALF_FP);
    w_y_fin       = w_ground ? c_Y_GND_P : w_y_wall[PW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE, c_ST_SCORED: if (serve) w_state_nxt = c_ST_FLIGHT;
      c_ST_FLIGHT: if (w_tick && (w_over || w_ground)) w_state_nxt = c_ST_SCORED;
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Over-touch pre-empts ground so the two pulses are mutually exclusive.
  always_comb begin
    w_ovr_nxt   = w_flight_tick & w_over;
    w_gnd_nxt   = w_flight_tick & ~w_over & w_ground;
    w_fault_nxt = r_fault;
    if (w_ovr_nxt)      w_fault_nxt = w_hit_side;
    else if (w_gnd_nxt) w_fault_nxt = w_ground_side;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_pl1_d    <= 1'b0;
      r_pl2_d    <= 1'b0;
      r_net_d    <= 1'b0;
      r_pl1_pend <= 1'b0;
      r_pl2_pend <= 1'b0;
      r_net_pend <= 1'b0;
      r_gnd      <= 1'b0;
      r_ovr      <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_pl1_d    <= pl1_col;
      r_pl2_d    <= pl2_col;
      r_net_d    <= net_col;
      // An edge coinciding with the tick survives into the next tick window.
      r_pl1_pend <= (pl1_col & ~r_pl1_d) | (r_pl1_pend & ~w_tick);
      r_pl2_pend <= (pl2_col & ~r_pl2_d) | (r_pl2_pend & ~w_tick);
      r_net_pend <= (net_col & ~r_net_d) | (r_net_pend & ~w_tick);
      r_gnd      <= w_gnd_nxt;
      r_ovr      <= w_ovr_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_px        <= c_SX1;
      r_py        <= c_SY;
      r_vx        <= '0;
      r_vy        <= '0;
      r_touch     <= 2'd0;
      r_last_side <= 1'b0;
    end else if (r_state != c_ST_FLIGHT) begin
      r_vx <= '0;
      r_vy <= '0;
      if (serve) begin
        r_px    <= serve_side ? c_SX2 : c_SX1;
        r_py    <= c_SY;
        r_touch <= 2'd0;
      end
    end else if (w_tick) begin
      if (w_hit) begin
        r_touch     <= w_touch_nxt;
        r_last_side <= w_hit_side;
      end
      if (w_over || w_ground) begin
        r_vx <= '0;
        r_vy <= '0;
      end else begin
        r_vx <= w_vx2;
        r_vy <= w_vy2;
      end
      if (!w_over) begin
        r_px <= w_x_wall[PW-1:0];
        r_py <= w_y_fin;
      end
    end
  end

  assign ball_posx_out = r_px[PW-1:FRAC];
  assign ball_posy_out = r_py[PW-1:FRAC];
  assign gnd_col       = r_gnd;
  assign ovr_touch     = r_ovr;
  assign fault_side    = r_fault;
  assign touch_cnt     = r_touch;
  assign state_out     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ball_motion_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ball_motion_ctrl
// Brief    : Scoreboard bench for ball_motion_ctrl with TICK_DIV = 4; honours
//            BALL_TOUCH_LIMIT_EN when deciding the fourth-touch outcome.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ball_motion_ctrl;
  logic        clk = 1'b0;
  logic        rst, serve, serve_side, pl1_col, pl2_col, net_col;
  logic [11:0] pl1_posx, pl2_posx, ball_posx_out, ball_posy_out;
  logic        gnd_col, ovr_touch, fault_side;
  logic [1:0]  touch_cnt, state_out;

  ball_motion_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .serve(serve), .serve_side(serve_side),
    .pl1_col(pl1_col), .pl2_col(pl2_col), .net_col(net_col),
    .pl1_posx(pl1_posx), .pl2_posx(pl2_posx),
    .ball_posx_out(ball_posx_out), .ball_posy_out(ball_posy_out),
    .gnd_col(gnd_col), .ovr_touch(ovr_touch), .fault_side(fault_side),
    .touch_cnt(touch_cnt), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct { string name; int at; int x; int y; int st; int tc; } exp_t;
  typedef struct { string name; int at; bit gnd; bit ovr; bit fs; } pexp_t;
  exp_t  oq[$];
  pexp_t pq[$];
  exp_t  e;
  pexp_t p;
  int gcnt = 0, ecnt = 0, checks = 0, failures = 0;

  always @(posedge clk) gcnt <= gcnt + 1;
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  task automatic expo(input string n, input int x, input int y, input int st, input int tc);
    oq.push_back('{n, gcnt, x, y, st, tc});
  endtask

  task automatic expp(input string n, input bit g, input bit o, input bit f);
    pq.push_back('{n, gcnt, g, o, f});
  endtask

  // Advance to the negedge after the next physics-tick clock edge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      while (ecnt % 4 != 0) @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    #1;
    while (oq.size() > 0 && oq[0].at <= gcnt) begin
      e = oq.pop_front();
      checks++;
      if (e.at != gcnt || int'(ball_posx_out) != e.x || int'(ball_posy_out) != e.y ||
          int'(state_out) != e.st || int'(touch_cnt) != e.tc) begin
        failures++;
        $display("FAIL %s: got x=%0d y=%0d st=%0d tc=%0d want x=%0d y=%0d st=%0d tc=%0d",
                 e.name, ball_posx_out, ball_posy_out, state_out, touch_cnt, e.x, e.y, e.st, e.tc);
      end
    end
    if (pq.size() > 0 && pq[0].at < gcnt) begin
      p = pq.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: pulse missing, got none want gnd=%0d ovr=%0d", p.name, p.gnd, p.ovr);
    end
    if (gnd_col || ovr_touch) begin
      checks++;
      if (pq.size() == 0 || pq[0].at != gcnt) begin
        failures++;
        $display("FAIL unexpected_pulse: got gnd=%0d ovr=%0d fs=%0d want no pulse", gnd_col, ovr_touch, fault_side);
      end else begin
        p = pq.pop_front();
        if (gnd_col != p.gnd || ovr_touch != p.ovr || fault_side != p.fs) begin
          failures++;
          $display("FAIL %s: got gnd=%0d ovr=%0d fs=%0d want gnd=%0d ovr=%0d fs=%0d",
                   p.name, gnd_col, ovr_touch, fault_side, p.gnd, p.ovr, p.fs);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ot_x[3] = '{206, 212, 218};
    int ot_y[3] = '{190, 180, 170};
    int nt_x[7] = '{20, 20, 26, 32, 38, 44, 50};
    int nt_y[7] = '{134, 140, 147, 155, 163, 171, 180};
    rst = 1'b1; serve = 1'b0; serve_side = 1'b0;
    pl1_col = 1'b0; pl2_col = 1'b0; net_col = 1'b0;
    pl1_posx = '0; pl2_posx = '0;
    repeat (3) @(negedge clk);
    expo("reset_state", 200, 200, 0, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    expo("idle_hold", 200, 200, 0, 0);

    // Serve from pl1 and fall under gravity.
    wait_ticks(1);
    serve = 1'b1; serve_side = 1'b0;
    @(negedge clk); serve = 1'b0;
    expo("serve_pl1", 200, 200, 1, 0);
    wait_ticks(1); expo("grav_t1", 200, 200, 1, 0);
    wait_ticks(1); expo("grav_t2", 200, 201, 1, 0);
    wait_ticks(1); expo("grav_t3", 200, 203, 1, 0);

    pl1_posx = 12'd190; pl1_col = 1'b1;
    @(negedge clk); pl1_col = 1'b0;
    wait_ticks(1); expo("pl1_hit", 205, 193, 1, 1);
    wait_ticks(1); expo("after_hit", 210, 183, 1, 1);

    @(negedge clk); rst = 1'b1;
    expo("rst_midflight", 200, 200, 0, 0);
    @(negedge clk); rst = 1'b0;

    // Four consecutive pl2 touches.
    wait_ticks(1);
    serve = 1'b1; serve_side = 1'b0;
    @(negedge clk); serve = 1'b0;
    pl2_posx = 12'd0;
    for (int i = 0; i < 4; i++) begin
      pl2_col = 1'b1;
      @(negedge clk); pl2_col = 1'b0;
      wait_ticks(1);
      if (i < 3) begin
        expo("pl2_touch", ot_x[i], ot_y[i], 1, i + 1);
      end else begin
`ifdef BALL_TOUCH_LIMIT_EN
        expp("ovr_touch", 1'b0, 1'b1, 1'b1);
        expo("ovr_scored", 218, 170, 2, 3);
`else
        expo("touch_sat", 224, 160, 1, 3);
`endif
      end
    end
`ifdef BALL_TOUCH_LIMIT_EN
    wait_ticks(1); expo("ovr_hold", 218, 170, 2, 3);
`endif

    // Left wall bounce, then net held across seven ticks.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    wait_ticks(1);
    serve = 1'b1; serve_side = 1'b0;
    @(negedge clk); serve = 1'b0;
    pl1_posx = 12'd799; pl1_col = 1'b1;
    @(negedge clk); pl1_col = 1'b0;
    wait_ticks(1);  expo("left_hit", 194, 190, 1, 1);
    wait_ticks(28); expo("near_wall", 26, 113, 1, 1);
    wait_ticks(1);  expo("at_wall", 20, 117, 1, 1);
    wait_ticks(1);  expo("wall_clamp", 20, 122, 1, 1);
    wait_ticks(1);  expo("wall_rebound", 26, 128, 1, 1);
    net_col = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_ticks(1);
      expo("net_held", nt_x[i], nt_y[i], 1, 1);
    end
    net_col = 1'b0;

    wait_ticks(24); expo("pre_ground_pl1", 194, 546, 1, 1);
    wait_ticks(1);
    expp("gnd_pl1_half", 1'b1, 1'b0, 1'b0);
    expo("ground_pl1", 200, 560, 2, 1);

    // Serve from pl2 and drop to the ground on the pl2 half.
    wait_ticks(1);
    serve = 1'b1; serve_side = 1'b1;
    @(negedge clk); serve = 1'b0;
    expo("serve_pl2", 600, 200, 1, 0);
    wait_ticks(37); expo("pre_ground_pl2", 600, 551, 1, 0);
    wait_ticks(1);
    expp("gnd_pl2_half", 1'b1, 1'b0, 1'b1);
    expo("ground_pl2", 600, 560, 2, 0);

    pl1_posx = 12'd0; pl1_col = 1'b1;
    @(negedge clk); pl1_col = 1'b0;
    wait_ticks(3); expo("scored_hold", 600, 560, 2, 0);
    serve = 1'b1; serve_side = 1'b0;
    @(negedge clk); serve = 1'b0;
    expo("reserve", 200, 200, 1, 0);
    wait_ticks(1); expo("edge_discarded", 200, 200, 1, 0);

    repeat (3) @(negedge clk);
    #2;
    while (oq.size() > 0) begin
      e = oq.pop_front();
      checks++; failures++;
      $display("FAIL %s: got unchecked want checked", e.name);
    end
    while (pq.size() > 0) begin
      p = pq.pop_front();
      checks++; failures++;
      $display("FAIL %s: got no pulse want pulse", p.name);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
